// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline stall/flush
//               scheduler: stall bus type, stage indices, FSM states, stall
//               cause codes and the stall-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   localparam int STG_PC  = 0;
   localparam int STG_IF1 = 1;
   localparam int STG_IC  = 2;
   localparam int STG_ID  = 3;
   localparam int STG_EX  = 4;
   localparam int STG_DT  = 5;
   localparam int STG_DC  = 6;
   localparam int STG_MEM = 7;

   localparam int NUM_STAGES = STG_MEM + 1;

   // One bit per stage; STOP holds the stage, NO_STOP lets it advance.
   typedef logic [NUM_STAGES-1:0] stall_bus_t;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [1:0] {
      PC_RUN   = 2'd0,
      PC_FLUSH = 2'd1,
      PC_DRAIN = 2'd2
   } pc_state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE = 3'd0,
      CAUSE_IC   = 3'd1,
      CAUSE_LOAD = 3'd2,
      CAUSE_EX   = 3'd3,
      CAUSE_DC   = 3'd4
   } stall_cause_e;

   // Hold every stage at or below index h; h < 0 gives an all-clear bus.
   function automatic stall_bus_t hold_upto(input int h);
      stall_bus_t m;
      for (int k = 0; k < NUM_STAGES; k++) begin
         m[k] = (k <= h) ? STOP : NO_STOP;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Request/stall/redirect bundle between the pipeline stages
//               (master) and the stall/flush scheduler (slave).
//               Perf counter signals exist only when PIPE_CTRL_PERF_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
`ifdef PIPE_CTRL_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;

   logic        req_ic;
   logic        req_load;
   logic        req_ex;
   logic        req_dc;
   logic        excp_i;
   logic [31:0] excp_pc_i;
   stall_bus_t  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        wdog_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_ic;
   logic [CNT_W-1:0] perf_load;
   logic [CNT_W-1:0] perf_ex;
   logic [CNT_W-1:0] perf_dc;
   logic [CNT_W-1:0] perf_flush;
`endif

   modport master (
      output req_ic, req_load, req_ex, req_dc, excp_i, excp_pc_i,
      input  stall, flush, new_pc, wdog_err
`ifdef PIPE_CTRL_PERF_EN
      , input perf_ic, perf_load, perf_ex, perf_dc, perf_flush
`endif
   );

   modport slave (
      input  req_ic, req_load, req_ex, req_dc, excp_i, excp_pc_i,
      output stall, flush, new_pc, wdog_err
`ifdef PIPE_CTRL_PERF_EN
      , output perf_ic, perf_load, perf_ex, perf_dc, perf_flush
`endif
   );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_stall_encoder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stall_encoder
// Description : Combinational priority encoder: the deepest requesting stage
//               wins and every stage at or above it (towards pc) is held.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stall_encoder
   import pipe_ctrl_pkg::*;
(
   input  logic         req_ic,
   input  logic         req_load,
   input  logic         req_ex,
   input  logic         req_dc,
   output stall_bus_t   stall,
   output stall_cause_e cause
);

   // Deepest request wins: dc > ex > load > ic.
   always_comb begin
      cause = CAUSE_NONE;
      stall = '0;
      if (req_dc) begin
         cause = CAUSE_DC;
         stall = hold_upto(STG_DC);
      end else if (req_ex) begin
         cause = CAUSE_EX;
         stall = hold_upto(STG_EX);
      end else if (req_load) begin
         cause = CAUSE_LOAD;
         stall = hold_upto(STG_ID);
      end else if (req_ic) begin
         cause = CAUSE_IC;
         stall = hold_upto(STG_IC);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central stall/flush scheduler for the 8-stage pipeline.
//               Merges stall requests into the stall bus, sequences exception
//               redirects (RUN -> FLUSH -> DRAIN) and flags stalls that never
//               release. Optional perf counters: define PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int WDOG_CYCLES = 1024
`ifdef PIPE_CTRL_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);

   localparam int               WD_W     = $clog2(WDOG_CYCLES) + 1;
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WDOG_CYCLES);

   pc_state_e    state;
   pc_state_e    state_nxt;
   logic [31:0]  pend_pc;
   logic         excp_pend;
   logic         eff_ic;
   logic         eff_load;
   logic         eff_ex;
   logic         eff_dc;
   logic         flush_c;
   stall_bus_t   drain_hold;
   stall_bus_t   enc_stall;
   stall_cause_e cause;
   logic         stalled;
   logic [WD_W-1:0] wd_cnt;
   logic         wdog_err_q;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PC_RUN;
      else     state <= state_nxt;
   end

   // Next state and request gating. Only req_dc may reach the encoder
   // outside RUN; FLUSH forces the bus clear, DRAIN holds pc for reload.
   always_comb begin
      state_nxt  = state;
      flush_c    = 1'b0;
      drain_hold = '0;
      eff_ic     = 1'b0;
      eff_load   = 1'b0;
      eff_ex     = 1'b0;
      eff_dc     = 1'b0;
      case (state)
         PC_RUN: begin
            eff_ic   = bus.req_ic;
            eff_load = bus.req_load;
            eff_ex   = bus.req_ex;
            eff_dc   = bus.req_dc;
            if ((bus.excp_i || excp_pend) && !bus.req_dc) state_nxt = PC_FLUSH;
         end
         PC_FLUSH: begin
            flush_c   = 1'b1;
            state_nxt = PC_DRAIN;
         end
         PC_DRAIN: begin
            eff_dc     = bus.req_dc;
            drain_hold = hold_upto(STG_PC);
            state_nxt  = PC_RUN;
         end
         default: state_nxt = PC_RUN;
      endcase
   end

   pipe_ctrl_stall_encoder u_enc (
      .req_ic   (eff_ic),
      .req_load (eff_load),
      .req_ex   (eff_ex),
      .req_dc   (eff_dc),
      .stall    (enc_stall),
      .cause    (cause)
   );

   assign bus.stall  = enc_stall | drain_hold;
   assign bus.flush  = flush_c;
   assign bus.new_pc = flush_c ? pend_pc : 32'h0;
   assign stalled    = (cause != CAUSE_NONE) || (drain_hold[STG_PC] == STOP);

   // Redirect target capture: the first exception seen in RUN owns the
   // target; later ones are dropped because a flush is already coming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_pc   <= 32'h0;
         excp_pend <= 1'b0;
      end else if (state == PC_RUN) begin
         if (bus.excp_i && !excp_pend) pend_pc <= bus.excp_pc_i;
         if (bus.excp_i && bus.req_dc) excp_pend <= 1'b1;
      end else if (state == PC_FLUSH) begin
         excp_pend <= 1'b0;
      end
   end

   // Watchdog: count consecutive stalled cycles, saturate at the limit and
   // leave a sticky error behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt     <= '0;
         wdog_err_q <= 1'b0;
      end else if (!stalled || flush_c) begin
         wd_cnt <= '0;
      end else if (wd_cnt != WD_LIMIT) begin
         wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_cnt == WD_LIMIT - WD_W'(1)) wdog_err_q <= 1'b1;
      end
   end

   assign bus.wdog_err = wdog_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_ic_q;
   logic [CNT_W-1:0] perf_load_q;
   logic [CNT_W-1:0] perf_ex_q;
   logic [CNT_W-1:0] perf_dc_q;
   logic [CNT_W-1:0] perf_flush_q;

   // Perf counters: one tick per cycle for the winning stall cause, one
   // per FLUSH entry; all wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_ic_q    <= '0;
         perf_load_q  <= '0;
         perf_ex_q    <= '0;
         perf_dc_q    <= '0;
         perf_flush_q <= '0;
      end else begin
         case (cause)
            CAUSE_IC:   perf_ic_q   <= perf_ic_q   + CNT_W'(1);
            CAUSE_LOAD: perf_load_q <= perf_load_q + CNT_W'(1);
            CAUSE_EX:   perf_ex_q   <= perf_ex_q   + CNT_W'(1);
            CAUSE_DC:   perf_dc_q   <= perf_dc_q   + CNT_W'(1);
            default: ;
         endcase
         if (state == PC_FLUSH) perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
   end

   assign bus.perf_ic    = perf_ic_q;
   assign bus.perf_load  = perf_load_q;
   assign bus.perf_ex    = perf_ex_q;
   assign bus.perf_dc    = perf_dc_q;
   assign bus.perf_flush = perf_flush_q;
`else
`endif

endmodule
`default_nettype wire
